// File: rtl/alu_share_arb.sv
// Shares one combinational 32-bit ALU between two requesters.
// Requests are granted round-robin on ties, with one operation in flight at a time.
module alu_share_arb #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [WIDTH-1:0]  alu_data1,
  output logic [WIDTH-1:0]  alu_data2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_out,
  output logic              rsp0_valid,
  output logic [WIDTH-1:0]  rsp0_data,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  output logic [WIDTH-1:0]  rsp1_data,
  input  logic              rsp1_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] result;
  logic             gnt0;
  logic             gnt1;
  logic             rsp_ack;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_data  = result;
  assign rsp1_data  = result;
  assign rsp_ack    = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_data1  <= '0;
      alu_data2  <= '0;
      alu_ctrl   <= '0;
      result     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            alu_data1  <= gnt1 ? req1_a : req0_a;
            alu_data2  <= gnt1 ? req1_b : req0_b;
            alu_ctrl   <= gnt1 ? req1_ctrl : req0_ctrl;
            owner      <= gnt1;
            last_grant <= gnt1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result     <= alu_out;
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          // Only the owner's ready releases the response.
          if (rsp_ack) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small behavioural ALU on the shared port.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl, alu_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_data1, alu_data2, alu_out;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    alu_model = a & b;
      4'd1:    alu_model = a | b;
      4'd2:    alu_model = a + b;
      4'd3:    alu_model = a - b;
      4'd7:    alu_model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11:   alu_model = a << b[4:0];
      4'd13:   alu_model = $unsigned($signed(a) >>> b[4:0]);
      default: alu_model = 32'd0;
    endcase
  endfunction

  assign alu_out = alu_model(alu_ctrl, alu_data1, alu_data2);

  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then let inputs and outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_ctrl = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_ctrl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step();
    check("rst_alu_d1", alu_data1, 32'd0);
    check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_rsp_data", rsp0_data, 32'd0);
    rst = 1'b0;
    step();

    // Single op from port 0: 5 + 7
    req0_valid = 1'b1; req0_ctrl = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    settle();
    check("t1_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    settle();
    check("t1_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("t1_alu_d1", alu_data1, 32'd5);
    check("t1_exec_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    step();
    check("t1_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    check("t1_rsp_data", rsp0_data, 32'd12);
    rsp0_ready = 1'b1;
    step();
    check("t1_done_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    rsp0_ready = 1'b0;

    // Both ports hammer the ALU; grants alternate starting with port 0
    rst = 1'b1; settle(); rst = 1'b0; step();
    req0_valid = 1'b1; req0_ctrl = 4'd3; req0_a = 32'd10;         req0_b = 32'd3;
    req1_valid = 1'b1; req1_ctrl = 4'd7; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_gnt;
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("t2_grant%0d", i), {30'd0, req1_ready, req0_ready}, {30'd0, exp_gnt});
      step();
      check($sformatf("t2_exec%0d", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      check($sformatf("t2_valid%0d", i), {30'd0, rsp1_valid, rsp0_valid}, {30'd0, exp_gnt});
      check($sformatf("t2_data%0d", i), exp_gnt[1] ? rsp1_data : rsp0_data, exp_gnt[1] ? 32'd1 : 32'd7);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    settle();

    // Port 1 arithmetic shift held under backpressure; port 0 ready stays low
    req1_valid = 1'b1; req1_ctrl = 4'd13; req1_a = 32'h8000_0000; req1_b = 32'd4;
    settle();
    check("t3_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
    rsp0_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_valid%0d", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      check($sformatf("t3_hold_data%0d", i), rsp1_data, 32'hF800_0000);
      check($sformatf("t3_hold_rdy%0d", i), {31'd0, req0_ready}, 32'd0);
      step();
    end
    rsp1_ready = 1'b1;
    settle();
    check("t3_last_valid", {31'd0, rsp1_valid}, 32'd1);
    step();
    rsp1_ready = 1'b0;
    check("t3_done_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("t3_next_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    check("t3_p0_data", rsp0_data, 32'd2);
    step();
    rsp0_ready = 1'b0;

    // Ready asserted in IDLE with nothing pending has no effect
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step(); step();
    check("t6_idle_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("t6_idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("t6_idle_alu", alu_data1, 32'd1);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset during EXEC
    req0_valid = 1'b1; req0_ctrl = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    step();
    req0_valid = 1'b0;
    rst = 1'b1; settle();
    check("t4_exec_alu_d1", alu_data1, 32'd0);
    check("t4_exec_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    rst = 1'b0;
    step(); step();
    check("t4_exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    // Reset during RESP
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    check("t4_resp_before", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    rst = 1'b1; settle();
    check("t4_resp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("t4_resp_data", rsp0_data, 32'd0);
    rst = 1'b0;
    step();
    check("t4_resp_gone", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    // Tie after reset goes to port 0; ctrl 15 yields 0, then SLL uses 5 shift bits
    req0_valid = 1'b1; req0_ctrl = 4'd15; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctrl = 4'd11; req1_a = 32'd1; req1_b = 32'd37;
    settle();
    check("t5_tie_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    check("t5_p0_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    check("t5_p0_data", rsp0_data, 32'd0);
    rsp1_ready = 1'b1;
    step();
    check("t5_wrong_ready", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    check("t5_p1_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    step();
    req1_valid = 1'b0;
    step();
    check("t5_p1_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    check("t5_p1_data", rsp1_data, 32'h0000_0020);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    check("t5_p1_done", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
